// File: rtl/hazard_pkg.sv
// Shared decode for the hazard/stall controller.
// Holds MIPS opcode/funct constants, the instruction-class enum, the
// Tuse/Tnew encodings (2-bit, 3 = none) and pure decode functions that
// map a 32-bit instruction word to class, destination register, Tuse per
// source and Tnew per stage.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam logic [1:0] T_NONE = 2'd3;

    typedef enum logic [3:0] {
        IC_NOP,
        IC_LOAD,
        IC_STORE,
        IC_ALU_R,
        IC_ALU_I,
        IC_LUI,
        IC_BRANCH,
        IC_J,
        IC_JAL,
        IC_JR,
        IC_JALR,
        IC_MD_START,
        IC_MD_MOVE
    } instr_class_e;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    function automatic instr_class_e decode_class(input logic [31:0] ir);
        instr_class_e cls;
        cls = IC_NOP;
        if (ir != 32'd0) begin
            case (ir[31:26])
                OP_RTYPE: begin
                    case (ir[5:0])
                        FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                        FN_XOR, FN_NOR, FN_SLT, FN_SLTU:      cls = IC_ALU_R;
                        FN_JR:                                cls = IC_JR;
                        FN_JALR:                              cls = IC_JALR;
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:   cls = IC_MD_START;
                        FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO:   cls = IC_MD_MOVE;
                        default:                              cls = IC_NOP;
                    endcase
                end
                OP_J:                                         cls = IC_J;
                OP_JAL:                                       cls = IC_JAL;
                OP_BEQ, OP_BNE:                               cls = IC_BRANCH;
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI:                     cls = IC_ALU_I;
                OP_LUI:                                       cls = IC_LUI;
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:          cls = IC_LOAD;
                OP_SB, OP_SH, OP_SW:                          cls = IC_STORE;
                default:                                      cls = IC_NOP;
            endcase
        end
        return cls;
    endfunction

    // mfhi/mflo write a GPR; mthi/mtlo only read one.
    function automatic logic is_md_read(input logic [31:0] ir);
        return (ir[5:0] == FN_MFHI) || (ir[5:0] == FN_MFLO);
    endfunction

    function automatic logic [4:0] decode_dst(input logic [31:0] ir);
        logic [4:0] dst;
        dst = 5'd0;
        case (decode_class(ir))
            IC_ALU_R, IC_JALR:          dst = ir[15:11];
            IC_MD_MOVE:                 dst = is_md_read(ir) ? ir[15:11] : 5'd0;
            IC_ALU_I, IC_LUI, IC_LOAD:  dst = ir[20:16];
            IC_JAL:                     dst = 5'd31;
            default:                    dst = 5'd0;
        endcase
        return dst;
    endfunction

    function automatic logic [1:0] decode_tuse_rs(input logic [31:0] ir);
        logic [1:0] t;
        t = T_NONE;
        case (decode_class(ir))
            IC_BRANCH, IC_JR, IC_JALR:                    t = 2'd0;
            IC_ALU_R, IC_MD_START, IC_ALU_I,
            IC_LOAD, IC_STORE:                            t = 2'd1;
            IC_MD_MOVE:                                   t = is_md_read(ir) ? T_NONE : 2'd1;
            default:                                      t = T_NONE;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] decode_tuse_rt(input logic [31:0] ir);
        logic [1:0] t;
        t = T_NONE;
        case (decode_class(ir))
            IC_BRANCH:              t = 2'd0;
            IC_ALU_R, IC_MD_START:  t = 2'd1;
            IC_STORE:               t = 2'd2;
            default:                t = T_NONE;
        endcase
        return t;
    endfunction

    // at_mem selects the EX/MEM view: everything but a load is ready there.
    function automatic logic [1:0] decode_tnew(input logic [31:0] ir, input logic at_mem);
        logic [1:0] t;
        t = T_NONE;
        case (decode_class(ir))
            IC_LOAD:                    t = at_mem ? 2'd1 : 2'd2;
            IC_ALU_R, IC_ALU_I, IC_LUI: t = at_mem ? 2'd0 : 2'd1;
            IC_MD_MOVE:                 t = is_md_read(ir) ? (at_mem ? 2'd0 : 2'd1) : T_NONE;
            IC_JAL, IC_JALR:            t = 2'd0;
            default:                    t = T_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// Multiply/divide busy timer.
// Issues a one-cycle md_start when an MD-start instruction sits in E while
// idle, then holds md_busy for exactly MULT_CYCLES or DIV_CYCLES cycles.
// Ports: clk, reset (sync, active-high), start_req (MD-start class in E),
//        is_div (that instruction is div/divu), md_start, md_busy.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   MD_IDLE | no result pending; a start_req launches the MDU
//   MD_BUSY | result pending; cnt counts down to terminal 1
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start_req,
    input  logic is_div,
    output logic md_start,
    output logic md_busy
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A start request while busy is dropped: no restart of the count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_start  = 1'b0;
        md_busy   = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start_req) begin
                    md_start  = 1'b1;
                    cnt_nxt   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = MD_IDLE;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline.
// Compares D against E and M using Tuse/Tnew, freezes PC and IF/ID and
// clears ID/EX on a hazard, and owns the MDU busy timer.
// Ports: clk, reset (sync, active-high), IR_D/IR_E/IR_M instruction words,
//        stall, PC_en, IF_ID_en, ID_EX_clr, md_start, md_busy,
//        stall_cycles (saturating count of stalled cycles).
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    output logic        stall,
    output logic        PC_en,
    output logic        IF_ID_en,
    output logic        ID_EX_clr,
    output logic        md_start,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    instr_class_e class_d, class_e;
    logic [4:0]   rs_d, rt_d, dst_e, dst_m;
    logic [1:0]   tuse_rs, tuse_rt, tnew_e, tnew_m;
    logic         data_stall, md_stall;

    assign class_d = decode_class(IR_D);
    assign class_e = decode_class(IR_E);
    assign rs_d    = IR_D[25:21];
    assign rt_d    = IR_D[20:16];
    assign tuse_rs = decode_tuse_rs(IR_D);
    assign tuse_rt = decode_tuse_rt(IR_D);
    assign dst_e   = decode_dst(IR_E);
    assign dst_m   = decode_dst(IR_M);
    assign tnew_e  = decode_tnew(IR_E, 1'b0);
    assign tnew_m  = decode_tnew(IR_M, 1'b1);

    // Tuse of 3 (unused source) is never below a real Tnew (max 2).
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] dst, input logic [1:0] tnew);
        return (src != 5'd0) && (tnew != T_NONE) && (src == dst) && (tuse < tnew);
    endfunction

    assign data_stall = src_hazard(rs_d, tuse_rs, dst_e, tnew_e)
                      | src_hazard(rt_d, tuse_rt, dst_e, tnew_e)
                      | src_hazard(rs_d, tuse_rs, dst_m, tnew_m)
                      | src_hazard(rt_d, tuse_rt, dst_m, tnew_m);

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk       (clk),
        .reset     (reset),
        .start_req (class_e == IC_MD_START),
        .is_div    (IR_E[1]),
        .md_start  (md_start),
        .md_busy   (md_busy)
    );

    // md_start is included so an MD op in D cannot slip in behind the
    // starting one before md_busy rises.
    assign md_stall = ((class_d == IC_MD_START) || (class_d == IC_MD_MOVE))
                      && (md_busy || md_start);

    assign stall     = data_stall | md_stall;
    assign PC_en     = ~stall;
    assign IF_ID_en  = ~stall;
    assign ID_EX_clr = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_D, IR_E, IR_M;
    logic        stall, PC_en, IF_ID_en, ID_EX_clr, md_start, md_busy;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        s;
        logic        ms;
        logic        mb;
        logic [31:0] sc;
        string       name;
    } exp_t;

    exp_t q[$];

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .IR_D         (IR_D),
        .IR_E         (IR_E),
        .IR_M         (IR_M),
        .stall        (stall),
        .PC_en        (PC_en),
        .IF_ID_en     (IF_ID_en),
        .ID_EX_clr    (ID_EX_clr),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    // Drive one cycle of inputs and record the outputs expected for it.
    task automatic step(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                        input logic rst, input logic s, input logic ms, input logic mb,
                        input logic [31:0] sc, input string name);
        exp_t x;
        @(posedge clk);
        #1;
        IR_D  = d;
        IR_E  = e;
        IR_M  = m;
        reset = rst;
        x.s = s; x.ms = ms; x.mb = mb; x.sc = sc; x.name = name;
        q.push_back(x);
    endtask

    // Monitor: combinational outputs are settled by the falling edge.
    initial begin
        exp_t x;
        logic [5:0] want, got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                x    = q.pop_front();
                want = {x.s, ~x.s, ~x.s, x.s, x.ms, x.mb};
                got  = {stall, PC_en, IF_ID_en, ID_EX_clr, md_start, md_busy};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL %s ctl{stall,pc_en,if_id_en,clr,md_start,md_busy}: got %b want %b",
                             x.name, got, want);
                end
                total++;
                if (stall_cycles !== x.sc) begin
                    bad++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", x.name, stall_cycles, x.sc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lw1, add2_13, add1_23, beq1, lw5, sw5_6, lw6, add3_12, addi0, lw0;
        logic [31:0] beq00, add0, jal, jr31, addi31, mflo8, mult, div_, mthi1, mfhi2;
        int wait_cyc;

        lw1     = enc_i('h23, 2, 1, 0);
        add2_13 = enc_r(1, 3, 2, 'h20);
        add1_23 = enc_r(2, 3, 1, 'h20);
        beq1    = enc_i('h04, 1, 0, 4);
        lw5     = enc_i('h23, 7, 5, 0);
        sw5_6   = enc_i('h2b, 6, 5, 0);
        lw6     = enc_i('h23, 7, 6, 0);
        add3_12 = enc_r(1, 2, 3, 'h20);
        addi0   = enc_i('h08, 1, 0, 5);
        lw0     = enc_i('h23, 2, 0, 0);
        beq00   = enc_i('h04, 0, 0, 4);
        add0    = enc_r(1, 2, 0, 'h20);
        jal     = {6'h03, 26'h40};
        jr31    = enc_r(31, 0, 0, 'h08);
        addi31  = enc_i('h08, 1, 31, 8);
        mflo8   = enc_r(0, 0, 8, 'h12);
        mult    = enc_r(4, 5, 0, 'h18);
        div_    = enc_r(4, 5, 0, 'h1a);
        mthi1   = enc_r(1, 0, 0, 'h11);
        mfhi2   = enc_r(0, 0, 2, 'h10);

        reset = 1'b1;
        IR_D  = '0;
        IR_E  = '0;
        IR_M  = '0;
        repeat (2) @(posedge clk);

        step('0, '0, '0, 0, 0, 0, 0, 0, "reset_state");
        step(add2_13, lw1, '0, 0, 1, 0, 0, 0, "load_use_E");
        step(add2_13, '0, lw1, 0, 0, 0, 0, 1, "load_use_M_clear");
        step(beq1, add1_23, '0, 0, 1, 0, 0, 1, "branch_alu_E");
        step(beq1, '0, add1_23, 0, 0, 0, 0, 2, "branch_alu_M_clear");
        step(beq1, '0, lw1, 0, 1, 0, 0, 2, "branch_load_M");
        step(sw5_6, lw5, '0, 0, 0, 0, 0, 3, "store_rt_tuse2");
        step(sw5_6, lw6, '0, 0, 1, 0, 0, 3, "store_base_load");
        step(add3_12, addi0, lw0, 0, 0, 0, 0, 4, "dst_zero_EM");
        step(beq00, add0, lw0, 0, 0, 0, 0, 4, "src_zero");
        step(jr31, jal, '0, 0, 0, 0, 0, 4, "jr_after_jal");
        step(jr31, addi31, '0, 0, 1, 0, 0, 4, "jr_after_addi");

        step(mflo8, mult, '0, 0, 1, 1, 0, 5, "mult_start_mflo");
        for (int i = 0; i < 5; i++)
            step(mflo8, '0, (i == 0) ? mult : '0, 0, 1, 0, 1, 32'(6 + i), "mult_busy_mflo");
        step(mflo8, '0, '0, 0, 0, 0, 0, 11, "mflo_released");

        step('0, div_, '0, 0, 0, 1, 0, 11, "div_start");
        step('0, '0, div_, 0, 0, 0, 1, 11, "div_busy1");
        step('0, '0, '0, 0, 0, 0, 1, 11, "div_busy2");
        step('0, '0, '0, 1, 0, 0, 1, 11, "div_busy3_reset");
        step('0, '0, '0, 0, 0, 0, 0, 0, "after_reset");

        step('0, mult, '0, 0, 0, 1, 0, 0, "mult_start2");
        step(mthi1, lw1, mult, 0, 1, 0, 1, 0, "md_and_data");
        for (int i = 0; i < 4; i++)
            step(mthi1, '0, (i == 0) ? lw1 : '0, 0, 1, 0, 1, 32'(1 + i), "md_only");
        step(mthi1, '0, '0, 0, 0, 0, 0, 5, "mthi_released");

        step('0, div_, '0, 0, 0, 1, 0, 5, "div_start2");
        for (int i = 0; i < 10; i++)
            step(mfhi2, '0, '0, 0, 1, 0, 1, 32'(5 + i), "div_busy_mfhi");
        step(mfhi2, '0, '0, 0, 0, 0, 0, 15, "mfhi_released");

        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations still pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
